// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between the upstream sequencing FSM and mem_access_ctrl.
// o_accessCount is present only when ACCESS_COUNT_EN is defined.
interface mem_access_ctrl_if;
  logic       i_operation;
  logic       i_select;
  logic [2:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;
  logic       o_busy;
  logic       o_done;
`ifdef ACCESS_COUNT_EN
  logic [7:0] o_accessCount;
`endif

  modport master (
`ifdef ACCESS_COUNT_EN
    input  o_accessCount,
`endif
    output i_operation, i_select, i_addr, i_wdata,
    input  o_rdata, o_busy, o_done
  );

  modport slave (
`ifdef ACCESS_COUNT_EN
    output o_accessCount,
`endif
    input  i_operation, i_select, i_addr, i_wdata,
    output o_rdata, o_busy, o_done
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Edge-triggered single-request access controller for an 8x8 register array.
// Optional completed-access counter on o_accessCount, enabled by ACCESS_COUNT_EN.
module mem_access_ctrl (
  input  logic               i_clock,
  input  logic               i_reset,
  mem_access_ctrl_if.slave   bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                sel_prev;
  logic                req_c;
  logic                capture_c;
  logic                access_c;
  logic                op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Rising edge of the request level; the previous-select flop runs every cycle.
  assign req_c = bus.i_select & ~sel_prev;

  always_comb begin
    state_nx  = IDLE;
    capture_c = 1'b0;
    access_c  = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          state_nx  = ACCESS;
          capture_c = 1'b1;
        end
      end
      ACCESS: begin
        access_c = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      sel_prev <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      state    <= state_nx;
      sel_prev <= bus.i_select;
      busy_q   <= (state_nx != IDLE);
      done_q   <= (state_nx == DONE);
      if (capture_c) begin
        op_q    <= bus.i_operation;
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_wdata;
      end
      if (access_c) begin
        if (op_q) begin
          mem[addr_q] <= wdata_q;
        end else begin
          rdata_q <= mem[addr_q];
        end
      end
    end
  end

  assign bus.o_rdata = rdata_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

`ifdef ACCESS_COUNT_EN
  logic [7:0] count_q;

  // Counts DONE cycles; wraps naturally at 8 bits.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (state == DONE) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign bus.o_accessCount = count_q;
`endif

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001: i_clock  input  1  sole clock; all state updates on rising edge SHALL use it.
REQ-002: i_reset  input  1  synchronous, active-high reset; SHALL take effect only on a rising i_clock edge.
REQ-003: i_operation  input  1  access type from upstream FSM operationOut; SHALL mean 1 = write, 0 = read.
REQ-004: i_select  input  1  request level from upstream FSM selectOut; its rising edge SHALL be the request.
REQ-005: i_addr  input  3  word address 0..7.
REQ-006: i_wdata  input  8  write data.
REQ-007: o_rdata  output  8  read data, registered.
REQ-008: o_busy  output  1  high while a request is in progress.
REQ-009: o_done  output  1  single-cycle completion pulse.
REQ-010: o_accessCount  output  8  completed-access counter; SHALL exist only under ACCESS_COUNT_EN.

Function
REQ-011: Block SHALL hold an 8-word x 8-bit register array.
REQ-012: Request edge SHALL be detected as i_select=1 with registered previous i_select=0; previous-select register SHALL update every cycle, including while busy.
REQ-013: FSM states SHALL be IDLE, ACCESS and DONE, with 2-bit encoding IDLE=00, ACCESS=01, DONE=10; 11 SHALL return to IDLE next cycle.
REQ-014: IDLE: on request edge at cycle N, block SHALL capture i_operation, i_addr and i_wdata and enter ACCESS at N+1; otherwise remain IDLE.
REQ-015: ACCESS: write SHALL commit mem[addr]=wdata; read SHALL load o_rdata=mem[addr]; next state SHALL be DONE.
REQ-016: DONE: o_done SHALL be 1 for exactly this cycle; next state SHALL be IDLE.
REQ-017: o_busy SHALL be 1 in ACCESS and DONE and 0 in IDLE.
REQ-018: Latency SHALL be fixed: edge at N, o_done at N+2, o_rdata valid at N+2.
REQ-019: o_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-020: Request edges arriving while o_busy=1 SHALL be dropped, not queued.
REQ-021: i_select held high after an accepted edge SHALL NOT re-trigger.
REQ-022: Read of an address in the cycle after a write to it completes SHALL return the new data.
REQ-023: Inputs other than i_select SHALL be ignored outside the capture cycle.

Reset
REQ-024: On i_reset=1, state SHALL become IDLE; o_busy, o_done and o_rdata SHALL be 0; all array words SHALL be 0x00; the previous-select register SHALL be 0.
REQ-025: Reset SHALL take priority over all other activity; reset asserted during ACCESS SHALL discard the pending write.
REQ-026: If i_select=1 in the first cycle after reset deasserts, that SHALL count as a request edge.

Configuration
REQ-027: Macro ACCESS_COUNT_EN SHALL control the access counter.
REQ-028: With ACCESS_COUNT_EN defined, o_accessCount SHALL reset to 0x00, increment once per DONE cycle, and wrap 0xFF->0x00.
REQ-029: Without ACCESS_COUNT_EN, port o_accessCount and its counter SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-030: Write then read: write 0xA5 to addr 3, then read addr 3 -> o_rdata=0xA5 at o_done, two cycles after the read edge.
REQ-031: Reset contents: after reset, read all addrs 0..7 -> each returns 0x00; o_busy and o_done are 0 during reset.
REQ-032: Held select: i_select held high for 10 cycles with write 0x3C to addr 7 -> exactly one o_done pulse; mem[7]=0x3C.
REQ-033: Busy drop: a second edge one cycle after an accepted edge (write 0x11 to addr 0) -> ignored; mem[0] unchanged; one o_done pulse.
REQ-034: Mid-operation reset: write 0xFF to addr 2, then i_reset during ACCESS -> mem[2]=0x00, o_busy=0 next cycle.
REQ-035: Counter wrap (ACCESS_COUNT_EN defined): 256 accesses -> o_accessCount=0x00; 257 accesses -> o_accessCount=0x01.
